// File: rtl/idma_axis_loopback_accel.sv
// AXI-Stream loopback accelerator model: ingress FIFO, fixed per-beat processing delay, in-order egress.
// Optional statistics counters are enabled with `define IDMA_AXIS_LOOPBACK_STATS_EN.
module idma_axis_loopback_accel #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned StrbWidth   = DataWidth/8,
  parameter int unsigned IdWidth     = 3,
  parameter int unsigned UserWidth   = 1,
  parameter int unsigned Depth       = 16,
  parameter int unsigned ProcLatency = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [DataWidth-1:0] s_tdata,
  input  logic [StrbWidth-1:0] s_tstrb,
  input  logic [StrbWidth-1:0] s_tkeep,
  input  logic                 s_tlast,
  input  logic [IdWidth-1:0]   s_tid,
  input  logic [UserWidth-1:0] s_tuser,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [DataWidth-1:0] m_tdata,
  output logic [StrbWidth-1:0] m_tstrb,
  output logic [StrbWidth-1:0] m_tkeep,
  output logic                 m_tlast,
  output logic [IdWidth-1:0]   m_tid,
  output logic [UserWidth-1:0] m_tuser,
  output logic                 busy_o
`ifdef IDMA_AXIS_LOOPBACK_STATS_EN
  ,
  output logic [31:0]          pkt_cnt_o,
  output logic [31:0]          beat_cnt_o
`endif
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned EW = DataWidth + 2*StrbWidth + 1 + IdWidth + UserWidth;
  localparam logic [3:0]  PL = 4'(ProcLatency);

  typedef enum logic [1:0] {IDLE, PROC, SEND} state_e;

  state_e          r_state, w_state_nxt;
  logic [EW-1:0]   r_mem [Depth];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count, w_count_nxt;
  logic            r_full;
  logic            w_push, w_pop, w_empty;
  logic [EW-1:0]   r_out;
  logic [3:0]      r_delay, w_delay_nxt;
  logic            r_drop, w_drop_nxt;

  assign w_empty  = (r_count == '0);
  assign s_tready = !r_full;
  assign w_push   = s_tvalid && !r_full && !flush_i;
  assign w_count_nxt = flush_i ? '0
                     : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (flush_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
      // Registered full: a same-cycle pop never frees a slot for a push.
      r_full  <= (w_count_nxt == (AW+1)'(Depth));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tuser};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay;
    w_drop_nxt  = r_drop;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!flush_i && !w_empty) begin
          w_pop       = 1'b1;
          w_delay_nxt = PL;
          w_state_nxt = (PL == 4'd0) ? SEND : PROC;
        end
      end
      PROC: begin
        if (flush_i)                w_state_nxt = IDLE;
        else if (r_delay <= 4'd1)   w_state_nxt = SEND;
        else                        w_delay_nxt = r_delay - 4'd1;
      end
      SEND: begin
        // A flushed-but-presented beat still completes; afterwards return to IDLE.
        if (flush_i) w_drop_nxt = 1'b1;
        if (m_tready) begin
          w_drop_nxt = 1'b0;
          if (!flush_i && !r_drop && !w_empty) begin
            w_pop       = 1'b1;
            w_delay_nxt = PL;
            w_state_nxt = (PL == 4'd0) ? SEND : PROC;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_delay <= '0;
      r_drop  <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_delay <= w_delay_nxt;
      r_drop  <= w_drop_nxt;
      if (w_pop) r_out <= r_mem[r_rptr];
    end
  end

  assign m_tvalid = (r_state == SEND);
  assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tuser} = r_out;
  assign busy_o   = !w_empty || (r_state != IDLE);

`ifdef IDMA_AXIS_LOOPBACK_STATS_EN
  logic [31:0] r_beat_cnt, r_pkt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else if (m_tvalid && m_tready) begin
      r_beat_cnt <= r_beat_cnt + 32'd1;
      if (m_tlast) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end

  assign beat_cnt_o = r_beat_cnt;
  assign pkt_cnt_o  = r_pkt_cnt;
`endif
endmodule

// File: tb/tb_idma_axis_loopback_accel.sv
// Scoreboard bench: one instance with ProcLatency=2, one with ProcLatency=0.
module tb_idma_axis_loopback_accel;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  s;
    logic [7:0]  k;
    logic        l;
    logic [2:0]  id;
    logic        u;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        flush, s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast, busy;
  logic [63:0] s_tdata, m_tdata;
  logic [7:0]  s_tstrb, s_tkeep, m_tstrb, m_tkeep;
  logic [2:0]  s_tid, m_tid;
  logic [0:0]  s_tuser, m_tuser;

  logic        z_flush, z_s_tvalid, z_s_tready, z_m_tvalid, z_m_tready, z_m_tlast, z_busy;
  logic [63:0] z_s_tdata, z_m_tdata;
  logic [7:0]  z_m_tstrb, z_m_tkeep;
  logic [2:0]  z_m_tid;
  logic [0:0]  z_m_tuser;
`ifdef IDMA_AXIS_LOOPBACK_STATS_EN
  logic [31:0] pkt_cnt, beat_cnt, z_pkt_cnt, z_beat_cnt;
`endif

  idma_axis_loopback_accel #(.ProcLatency(2)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tuser(m_tuser),
    .busy_o(busy)
`ifdef IDMA_AXIS_LOOPBACK_STATS_EN
    , .pkt_cnt_o(pkt_cnt), .beat_cnt_o(beat_cnt)
`endif
  );

  idma_axis_loopback_accel #(.ProcLatency(0)) u_dut_z (
    .clk(clk), .rst(rst), .flush_i(z_flush),
    .s_tvalid(z_s_tvalid), .s_tready(z_s_tready), .s_tdata(z_s_tdata), .s_tstrb(8'hff),
    .s_tkeep(8'hff), .s_tlast(1'b0), .s_tid(3'd0), .s_tuser(1'b0),
    .m_tvalid(z_m_tvalid), .m_tready(z_m_tready), .m_tdata(z_m_tdata), .m_tstrb(z_m_tstrb),
    .m_tkeep(z_m_tkeep), .m_tlast(z_m_tlast), .m_tid(z_m_tid), .m_tuser(z_m_tuser),
    .busy_o(z_busy)
`ifdef IDMA_AXIS_LOOPBACK_STATS_EN
    , .pkt_cnt_o(z_pkt_cnt), .beat_cnt_o(z_beat_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  beat_t exp_q[$];
  int    hs_q[$];
  int    nout = 0;
  int    first_acc = -1;
  int    first_vld = -1;

  // Egress monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && first_vld < 0) first_vld = cyc;
      if (m_tvalid && m_tready) begin
        nout++;
        hs_q.push_back(cyc + 1);
        if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 1);
        else chk("beat", {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tuser}, exp_q.pop_front());
      end
    end
  end

  logic [63:0] zexp = 64'd200;
  int          zhs[$];
  always @(negedge clk) begin
    if (!rst && z_m_tvalid && z_m_tready) begin
      chk("zero_data", z_m_tdata, zexp);
      zexp = zexp + 64'd1;
      zhs.push_back(cyc + 1);
    end
  end

  // Offers beats base, base+1, ... until n are accepted or max_cyc elapses.
  task automatic drive(input int n, input logic [63:0] base, input int max_cyc, output int acc);
    beat_t e;
    acc = 0;
    for (int c = 0; c < max_cyc && acc < n; c++) begin
      s_tvalid = 1'b1;
      s_tdata  = base + 64'(acc);
      s_tlast  = (acc == n - 1);
      s_tid    = 3'(acc);
      s_tuser  = 1'(acc);
      s_tstrb  = 8'(acc * 37 + 5);
      s_tkeep  = ~s_tstrb;
      @(negedge clk);
      if (s_tready && !flush) begin
        e = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tuser};
        exp_q.push_back(e);
        if (first_acc < 0) first_acc = cyc + 1;
        acc++;
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_empty(input int max_cyc);
    for (int c = 0; c < max_cyc && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  int acc, n0, zacc, zf_in;

  initial begin
    flush = 0; s_tvalid = 0; s_tdata = 0; s_tstrb = 0; s_tkeep = 0; s_tlast = 0;
    s_tid = 0; s_tuser = 0; m_tready = 1;
    z_flush = 0; z_s_tvalid = 0; z_s_tdata = 0; z_m_tready = 1;
    repeat (3) @(posedge clk); #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_tdata", m_tdata, 0);
    rst = 0;
    @(posedge clk); #1;

    // Basic loopback, ProcLatency=2
    first_acc = -1; first_vld = -1; n0 = hs_q.size();
    drive(16, 64'd1, 200, acc);
    chk("basic_acc", acc, 16);
    wait_empty(200);
    chk("basic_nhs", hs_q.size() - n0, 16);
    chk("basic_first_vld", first_vld - first_acc, 3);
    for (int i = n0 + 1; i < hs_q.size(); i++) chk("basic_gap", hs_q[i] - hs_q[i-1], 3);

    // Zero latency instance
    zacc = 0; zf_in = -1;
    for (int i = 0; i < 8; i++) begin
      z_s_tvalid = 1'b1;
      z_s_tdata  = 64'd200 + 64'(i);
      @(negedge clk);
      if (z_s_tready) begin
        if (zf_in < 0) zf_in = cyc + 1;
        zacc++;
      end
      @(posedge clk); #1;
    end
    z_s_tvalid = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("zero_acc", zacc, 8);
    chk("zero_nhs", zhs.size(), 8);
    if (zhs.size() > 0) chk("zero_first", zhs[0] - zf_in, 2);
    for (int i = 1; i < zhs.size(); i++) chk("zero_gap", zhs[i] - zhs[i-1], 1);

    // Backpressure: Depth + 1 beats fit
    m_tready = 0; n0 = nout;
    drive(20, 64'd1, 40, acc);
    chk("bp_acc", acc, 17);
    chk("bp_s_tready", s_tready, 0);
    chk("bp_m_tvalid", m_tvalid, 1);
    chk("bp_m_tdata", m_tdata, 1);
    repeat (5) @(posedge clk); #1;
    chk("bp_m_tvalid_hold", m_tvalid, 1);
    chk("bp_m_tdata_hold", m_tdata, 1);
    m_tready = 1;
    drive(3, 64'd18, 100, acc);
    chk("bp_rest_acc", acc, 3);
    wait_empty(200);
    chk("bp_nout", nout - n0, 20);

    // Flush with beat 1 presented
    m_tready = 0; n0 = nout;
    drive(5, 64'd50, 50, acc);
    for (int c = 0; c < 20 && !m_tvalid; c++) begin @(posedge clk); #1; end
    chk("flush_pre_vld", m_tvalid, 1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    repeat (3) @(posedge clk); #1;
    chk("flush_hold_vld", m_tvalid, 1);
    chk("flush_hold_data", m_tdata, 50);
    m_tready = 1;
    wait_empty(20);
    repeat (8) @(posedge clk); #1;
    chk("flush_busy", busy, 0);
    chk("flush_nout", nout - n0, 1);

    // Asynchronous reset mid-packet
    m_tready = 0;
    drive(4, 64'd70, 20, acc);
    rst = 1;
    #1;
    chk("arst_m_tvalid", m_tvalid, 0);
    chk("arst_s_tready", s_tready, 1);
    chk("arst_busy", busy, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    m_tready = 1; n0 = nout;
    drive(6, 64'd90, 50, acc);
    wait_empty(100);
    chk("arst_nout", nout - n0, 6);

`ifdef IDMA_AXIS_LOOPBACK_STATS_EN
    rst = 1;
    #1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    drive(16, 64'd300, 100, acc);
    wait_empty(200);
    drive(4, 64'd400, 50, acc);
    wait_empty(100);
    repeat (2) @(posedge clk); #1;
    chk("stat_beats", beat_cnt, 20);
    chk("stat_pkts", pkt_cnt, 2);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(posedge clk); #1;
    chk("stat_beats_flush", beat_cnt, 20);
    chk("stat_pkts_flush", pkt_cnt, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/idma_axis_loopback_accel.md
# idma_axis_loopback_accel

AXI-Stream loopback endpoint that stands in for an accelerator on the iDMA streaming backend. It consumes beats from the DMA's streaming write port (`streaming_wr_req_o` / `streaming_wr_rsp_i`), buffers them, and holds each beat for a fixed processing latency. It then returns the beats unchanged, in order, on the DMA's streaming read port (`streaming_rd_req_i` / `streaming_rd_rsp_o`). This closes the stream loop for the desc64-frontend / AXIS-backend system and provides a synthesizable, cycle-accurate accelerator model.

## Interface
Parameters:
- `DataWidth`, 64: width of tdata.
- `StrbWidth`, `DataWidth/8`: width of tstrb and tkeep.
- `IdWidth`, 3: width of tid.
- `UserWidth`, 1: width of tuser.
- `Depth`, 16: ingress FIFO entries. Must be a power of 2 and ≥2.
- `ProcLatency`, 2: processing cycles per beat. Range 0..15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: synchronous flush of buffered beats.
- `s_tvalid` in 1, `s_tready` out 1: ingress handshake (from DMA write stream).
- `s_tdata` in DataWidth, `s_tstrb` in StrbWidth, `s_tkeep` in StrbWidth, `s_tlast` in 1, `s_tid` in IdWidth, `s_tuser` in UserWidth: ingress payload.
- `m_tvalid` out 1, `m_tready` in 1: egress handshake (to DMA read stream).
- `m_tdata`, `m_tstrb`, `m_tkeep`, `m_tlast`, `m_tid`, `m_tuser`, out, same widths as the ingress fields: egress payload.
- `busy_o` out 1: high when the FIFO is non-empty or the FSM is not in IDLE.
- `pkt_cnt_o` out 32, `beat_cnt_o` out 32: statistics. Present only with the macro described under Configuration.

## Operation
- Ingress FIFO:
  - Stores {data, strb, keep, last, id, user}.
  - Occupancy counter is `$clog2(Depth)+1` bits.
  - `s_tready = !full`. The full flag is registered, so a push is never accepted while full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
- Output register holds the current beat. Delay counter is 4 bits.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the output register and load delay = ProcLatency. Go to PROC, or to SEND if ProcLatency==0.
  - PROC: decrement delay. When delay reaches 1, go to SEND.
  - SEND: drive `m_tvalid=1`. On `m_tvalid & m_tready`:
    - FIFO non-empty: pop the next beat and go to PROC, or stay in SEND if ProcLatency==0.
    - FIFO empty: go to IDLE.
- Payload passes through bit-exact. tlast, tid and tuser are preserved per beat. Beat order is strictly FIFO.
- AXI-Stream rules:
  - Once `m_tvalid` rises, it and all `m_*` payload fields stay stable until the handshake.
  - `m_tvalid` never depends combinationally on `m_tready`.
- `flush_i`:
  - Clears FIFO pointers and count on the next edge.
  - In IDLE or PROC: the FSM returns to IDLE and the output beat is discarded.
  - In SEND: the presented beat is kept until its handshake, then the FSM goes to IDLE.
  - An ingress push in the flush cycle is dropped. `s_tready` stays high.
- Reset values:
  - Outputs: `m_tvalid=0`, all `m_*` payload fields 0, `s_tready=1`, `busy_o=0`, counters 0.
  - Internal: FSM in IDLE, FIFO empty.
  - Reset mid-packet discards all state immediately (asynchronous).

## Timing
- Beat accepted at edge N is in the FIFO after N. IDLE pops it at edge N+1.
- `m_tvalid` rises after edge N+1+ProcLatency. With ProcLatency=0, `m_tvalid` is high in the cycle after edge N+1.
- Sustained throughput with `m_tready=1`:
  - ProcLatency=0: 1 beat/cycle.
  - Otherwise: 1 beat per ProcLatency+1 cycles.
- Maximum beats accepted while egress is stalled: Depth+1 (Depth in the FIFO plus one in the output register).

## Configuration
- `IDMA_AXIS_LOOPBACK_STATS_EN` defined:
  - `beat_cnt_o` increments on each egress handshake.
  - `pkt_cnt_o` increments on each egress handshake with `m_tlast=1`.
  - Both wrap at 2^32. Both are cleared by `rst` only, not by `flush_i`.
- Macro undefined: both ports and counters are absent.

## Test plan
- Basic loopback: 16 beats, data 1..16, `s_tlast` on beat 16, ProcLatency=2, `m_tready=1`.
  - Output is 1..16 in order, `m_tlast` only on beat 16.
  - Output handshakes are 3 cycles apart.
  - First `m_tvalid` rises 3 cycles after the first input handshake.
- Zero latency: ProcLatency=0, continuous input of 8 beats.
  - 8 consecutive output handshakes at 1 beat/cycle.
  - First output follows the first input by 2 edges.
- Backpressure: `m_tready=0`, Depth=16, 20 beats offered.
  - Exactly 17 accepted, then `s_tready=0`.
  - `m_tvalid` and `m_tdata=1` stay stable.
  - After releasing `m_tready`, all 17 beats emerge in order, then the remaining 3 are accepted and emerge.
- Flush: 5 beats buffered, beat 1 presented in SEND with `m_tready=0`, pulse `flush_i`.
  - Beat 1 is still delivered on `m_tready`.
  - Beats 2..5 are never output.
  - `busy_o=0` after the handshake.
- Reset mid-packet: assert `rst` with 4 beats in flight.
  - `m_tvalid=0`, `s_tready=1`, `busy_o=0` immediately.
  - A subsequent new packet loops back correctly.
- With `IDMA_AXIS_LOOPBACK_STATS_EN`: two packets of 16 and 4 beats.
  - `beat_cnt_o=20`, `pkt_cnt_o=2`.
  - After a `flush_i` pulse the values are unchanged.
